vga_pixel_source: RTL and testbench
===================================

Name: vga_pixel_source

Overview:
- Upstream neighbour of the per-channel ditherer. Generates VGA raster timing and fetches 24-bit RGB pixels from an external synchronous frame-buffer BRAM.
- Presents 8-bit red/green/blue channels to the ditherer with hsync/vsync/data-enable aligned to the data.
- Runs on the system clock. Pixel rate is set by a pixel clock-enable strobe.
- Image is IMG_W x IMG_H, placed at the top-left of the active area. Active pixels outside the image are black.

Parameters:
- H_ACTIVE, 640, active pixels per line
- H_FP, 16, horizontal front porch (pixels)
- H_SYNC, 96, hsync pulse width
- H_BP, 48, horizontal back porch
- V_ACTIVE, 480, active lines
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vsync pulse width
- V_BP, 33, vertical back porch
- IMG_W, 160, image width in pixels (≤ H_ACTIVE)
- IMG_H, 120, image height in lines (≤ V_ACTIVE)
- RD_LAT, 2, BRAM read latency in enabled cycles (≥1)
- ADDR_W, $clog2(IMG_W*IMG_H), frame-buffer address width (15 at defaults)

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- pix_ce  in  1  pixel tick; all state advances only when high
- mem_en  out  1  BRAM enable; equals pix_ce, forced 0 during rst
- mem_addr  out  ADDR_W  BRAM read address, registered
- mem_rdata  in  24  BRAM data {R[23:16],G[15:8],B[7:0]}, valid RD_LAT enabled cycles after address
- red  out  8  red channel to ditherer
- green  out  8  green channel
- blue  out  8  blue channel
- de  out  1  data enable (active region)
- hsync_n  out  1  horizontal sync, active low
- vsync_n  out  1  vertical sync, active low
- frame_start  out  1  one-clk pulse when pixel (0,0) appears on outputs

Behaviour:
- One clock (clk); reset is synchronous and active-high (rst).
- Reset values: h_cnt=v_cnt=0, addr=0, pipeline cleared, red=green=blue=0, de=0, hsync_n=vsync_n=1, frame_start=0, mem_addr=0, mem_en=0.
- rst has priority over pix_ce.
- Reset mid-frame abandons the frame. The first pix_ce after release processes (h,v)=(0,0) with address 0.
- Counters, on each pix_ce:
  - h_cnt 0..H_TOTAL-1, where H_TOTAL=H_ACTIVE+H_FP+H_SYNC+H_BP (800). It wraps to 0.
  - v_cnt increments on the h wrap, range 0..V_TOTAL-1 (525), and wraps to 0.
- Region flags, derived from the counter state:
  - active = h<H_ACTIVE && v<V_ACTIVE
  - in_img = h<IMG_W && v<IMG_H
  - hs = H_ACTIVE+H_FP ≤ h < H_ACTIVE+H_FP+H_SYNC (656..751)
  - vs = V_ACTIVE+V_FP ≤ v < V_ACTIVE+V_FP+V_SYNC (490..491)
- Address: a running counter with no multiplier.
  - mem_addr is issued for the current pixel when in_img.
  - It increments after each in_img pixel.
  - It resets to 0 when (h,v) wraps to (0,0).
  - The last image pixel uses address IMG_W*IMG_H-1 (19199). The counter never exceeds this value.
- Pipeline:
  - active, in_img, hs, vs and first=(h==0&&v==0) travel through an RD_LAT-deep shift register that advances only on pix_ce.
  - An output register, also loaded only on pix_ce, follows the shift register.
  - Total latency from counter state to output is RD_LAT+1 pix_ce ticks (3 at default).
- Output load on pix_ce:
  - de ← active_d
  - hsync_n ← ~hs_d
  - vsync_n ← ~vs_d
  - {red,green,blue} ← in_img_d ? mem_rdata : 24'h0
- Blanking forces rgb to 0 and de to 0.
- frame_start is high for exactly one clk, in the cycle after the output register loads first_d=1.
- Between pix_ce strobes all outputs hold. pix_ce may be high every clk (full-rate) or sparse.
- No arithmetic overflow: counter widths are $clog2(H_TOTAL) and $clog2(V_TOTAL).

Decomposition:
- vga_pkg holds:
  - default timing constants and derived H_TOTAL/V_TOTAL
  - typedef rgb_t, a packed struct {r,g,b} of 8-bit fields
  - typedef vga_ctrl_t, a packed {de,hs,vs,in_img,first}
- One sub-module, vga_timing: the h/v counters and region flags, advanced by pix_ce.
- The top level holds the address counter, the delay line and the output register.

Test Plan:
- Reset then 800*525 pix_ce at full rate, BRAM model with data=addr → 480 lines of de high for 640 ticks each. Hsync low ticks 656..751 of each line. Vsync low lines 490..491. Every edge delayed exactly 3 ticks from the counter.
- Image check → output pixel (x,y), x<160 and y<120, equals model data at y*160+x. Pixel (160,0) and pixel (0,120) are 0 with de=1. The last address seen is 19199.
- Sparse pix_ce (every 4th clk) → identical output sequence to full-rate. Outputs stable between strobes. frame_start is 1 clk wide, once per frame.
- Assert rst at (h=300,v=200) for 2 clks → outputs return to reset values. The next frame starts at mem_addr=0, and frame_start occurs 3 ticks after the first post-reset pix_ce.
- Two consecutive frames → mem_addr wraps 19199→0 at the frame boundary. frame_start pulses are exactly 420000 pix_ce apart.

Source files
------------

// File: rtl/vga_pkg.sv
// Shared timing defaults and data types for the VGA pixel source.
package vga_pkg;

    // Default 640x480 @ 60 Hz raster timing, in pixels and lines.
    localparam int H_ACTIVE_D = 640;
    localparam int H_FP_D     = 16;
    localparam int H_SYNC_D   = 96;
    localparam int H_BP_D     = 48;
    localparam int V_ACTIVE_D = 480;
    localparam int V_FP_D     = 10;
    localparam int V_SYNC_D   = 2;
    localparam int V_BP_D     = 33;

    localparam int H_TOTAL_D  = H_ACTIVE_D + H_FP_D + H_SYNC_D + H_BP_D;  // 800
    localparam int V_TOTAL_D  = V_ACTIVE_D + V_FP_D + V_SYNC_D + V_BP_D;  // 525

    // Default frame-buffer image size and BRAM read latency.
    localparam int IMG_W_D    = 160;
    localparam int IMG_H_D    = 120;
    localparam int RD_LAT_D   = 2;

    // One pixel as presented to the ditherer.
    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } rgb_t;

    // Region flags carried alongside the BRAM read.
    typedef struct packed {
        logic de;
        logic hs;
        logic vs;
        logic in_img;
        logic first;
    } vga_ctrl_t;

endpackage

// File: rtl/vga_timing.sv
// Horizontal/vertical raster counters and region flags, advanced by the pixel tick.
module vga_timing
    import vga_pkg::*;
#(
    parameter int H_ACTIVE = H_ACTIVE_D,
    parameter int H_FP     = H_FP_D,
    parameter int H_SYNC   = H_SYNC_D,
    parameter int H_BP     = H_BP_D,
    parameter int V_ACTIVE = V_ACTIVE_D,
    parameter int V_FP     = V_FP_D,
    parameter int V_SYNC   = V_SYNC_D,
    parameter int V_BP     = V_BP_D,
    parameter int IMG_W    = IMG_W_D,
    parameter int IMG_H    = IMG_H_D
) (
    input  logic clk,
    input  logic rst,
    input  logic i_pix_ce,
    output logic o_active,
    output logic o_in_img,
    output logic o_hs,
    output logic o_vs,
    output logic o_first,
    output logic o_wrap
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int H_W     = $clog2(H_TOTAL);
    localparam int V_W     = $clog2(V_TOTAL);

    // Boundaries sized to the counters so every compare is width-matched.
    localparam logic [H_W-1:0] H_LAST    = H_W'(H_TOTAL - 1);
    localparam logic [V_W-1:0] V_LAST    = V_W'(V_TOTAL - 1);
    localparam logic [H_W-1:0] H_ACT_C   = H_W'(H_ACTIVE);
    localparam logic [V_W-1:0] V_ACT_C   = V_W'(V_ACTIVE);
    localparam logic [H_W-1:0] H_IMG_C   = H_W'(IMG_W);
    localparam logic [V_W-1:0] V_IMG_C   = V_W'(IMG_H);
    localparam logic [H_W-1:0] HS_BEG    = H_W'(H_ACTIVE + H_FP);
    localparam logic [H_W-1:0] HS_END    = H_W'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [V_W-1:0] VS_BEG    = V_W'(V_ACTIVE + V_FP);
    localparam logic [V_W-1:0] VS_END    = V_W'(V_ACTIVE + V_FP + V_SYNC);

    logic [H_W-1:0] r_h;
    logic [V_W-1:0] r_v;

    // Step the raster position once per pixel tick, wrapping line then frame.
    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so every flop
        // samples pre-edge values regardless of statement order.
        if (rst) begin
            r_h <= '0;
            r_v <= '0;
        end else if (i_pix_ce) begin
            if (r_h == H_LAST) begin
                r_h <= '0;
                r_v <= (r_v == V_LAST) ? '0 : r_v + 1'b1;
            end else begin
                r_h <= r_h + 1'b1;
            end
        end
    end

    assign o_active = (r_h < H_ACT_C) && (r_v < V_ACT_C);
    assign o_in_img = (r_h < H_IMG_C) && (r_v < V_IMG_C);
    assign o_hs     = (r_h >= HS_BEG) && (r_h < HS_END);
    assign o_vs     = (r_v >= VS_BEG) && (r_v < VS_END);
    assign o_first  = (r_h == '0) && (r_v == '0);
    assign o_wrap   = (r_h == H_LAST) && (r_v == V_LAST);

endmodule

// File: rtl/vga_pixel_source.sv
// VGA raster source: frame-buffer address generation, BRAM-latency delay line
// and the registered RGB/sync output stage feeding the ditherer.
module vga_pixel_source
    import vga_pkg::*;
#(
    parameter int H_ACTIVE = H_ACTIVE_D,
    parameter int H_FP     = H_FP_D,
    parameter int H_SYNC   = H_SYNC_D,
    parameter int H_BP     = H_BP_D,
    parameter int V_ACTIVE = V_ACTIVE_D,
    parameter int V_FP     = V_FP_D,
    parameter int V_SYNC   = V_SYNC_D,
    parameter int V_BP     = V_BP_D,
    parameter int IMG_W    = IMG_W_D,
    parameter int IMG_H    = IMG_H_D,
    parameter int RD_LAT   = RD_LAT_D,
    parameter int ADDR_W   = $clog2(IMG_W * IMG_H)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              pix_ce,
    output logic              mem_en,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [23:0]       mem_rdata,
    output logic [7:0]        red,
    output logic [7:0]        green,
    output logic [7:0]        blue,
    output logic              de,
    output logic              hsync_n,
    output logic              vsync_n,
    output logic              frame_start
);

    localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(IMG_W * IMG_H - 1);

    logic      w_active;
    logic      w_in_img;
    logic      w_hs;
    logic      w_vs;
    logic      w_first;
    logic      w_wrap;
    vga_ctrl_t w_ctrl;
    vga_ctrl_t w_last;

    logic [ADDR_W-1:0] r_addr;
    vga_ctrl_t         r_dly [RD_LAT];
    rgb_t              r_rgb;
    logic              r_de;
    logic              r_hsync_n;
    logic              r_vsync_n;
    logic              r_frame_start;

    vga_timing #(
        .H_ACTIVE (H_ACTIVE),
        .H_FP     (H_FP),
        .H_SYNC   (H_SYNC),
        .H_BP     (H_BP),
        .V_ACTIVE (V_ACTIVE),
        .V_FP     (V_FP),
        .V_SYNC   (V_SYNC),
        .V_BP     (V_BP),
        .IMG_W    (IMG_W),
        .IMG_H    (IMG_H)
    ) u_timing (
        .clk      (clk),
        .rst      (rst),
        .i_pix_ce (pix_ce),
        .o_active (w_active),
        .o_in_img (w_in_img),
        .o_hs     (w_hs),
        .o_vs     (w_vs),
        .o_first  (w_first),
        .o_wrap   (w_wrap)
    );

    assign w_ctrl = '{de: w_active, hs: w_hs, vs: w_vs, in_img: w_in_img, first: w_first};
    assign w_last = r_dly[RD_LAT-1];

    // The BRAM is only clocked on pixel ticks so its latency counts in ticks.
    assign mem_en   = pix_ce & ~rst;
    // r_addr always holds the address of the current raster position's image
    // pixel, so the BRAM sees it in the same tick the flags enter the delay line.
    assign mem_addr = r_addr;

    // Running image address: +1 after each image pixel, saturating, cleared at frame wrap.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_addr <= '0;
        end else if (pix_ce) begin
            if (w_wrap) begin
                r_addr <= '0;
            end else if (w_in_img && (r_addr != ADDR_LAST)) begin
                r_addr <= r_addr + 1'b1;
            end
        end
    end

    // Delay the region flags by the BRAM read latency, one stage per pixel tick.
    always_ff @(posedge clk) begin
        // NOTE: this delay line is a handful of flops, not a RAM, so it is reset;
        // an abandoned frame must not leak stale sync or enable into the next one.
        if (rst) begin
            for (int i = 0; i < RD_LAT; i++) begin
                r_dly[i] <= '0;
            end
        end else if (pix_ce) begin
            r_dly[0] <= w_ctrl;
            for (int i = 1; i < RD_LAT; i++) begin
                r_dly[i] <= r_dly[i-1];
            end
        end
    end

    // Output stage: load aligned data and syncs on each tick, pulse frame_start for one clk.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rgb         <= '0;
            r_de          <= 1'b0;
            r_hsync_n     <= 1'b1;
            r_vsync_n     <= 1'b1;
            r_frame_start <= 1'b0;
        end else begin
            r_frame_start <= 1'b0;
            if (pix_ce) begin
                r_rgb         <= w_last.in_img ? rgb_t'(mem_rdata) : '0;
                r_de          <= w_last.de;
                r_hsync_n     <= ~w_last.hs;
                r_vsync_n     <= ~w_last.vs;
                r_frame_start <= w_last.first;
            end
        end
    end

    assign red         = r_rgb.r;
    assign green       = r_rgb.g;
    assign blue        = r_rgb.b;
    assign de          = r_de;
    assign hsync_n     = r_hsync_n;
    assign vsync_n     = r_vsync_n;
    assign frame_start = r_frame_start;

endmodule

// File: tb/tb_vga_pixel_source.sv
// Self-checking bench for vga_pixel_source on a scaled-down raster so whole
// frames fit in a short run. Expected outputs come from the raster position
// computed arithmetically from the number of pixel ticks since reset.
module tb_vga_pixel_source;

    // Scaled raster: 25 x 17 = 425 ticks per frame, 6 x 4 image.
    localparam int H_ACTIVE = 16;
    localparam int H_FP     = 2;
    localparam int H_SYNC   = 4;
    localparam int H_BP     = 3;
    localparam int V_ACTIVE = 10;
    localparam int V_FP     = 2;
    localparam int V_SYNC   = 2;
    localparam int V_BP     = 3;
    localparam int IMG_W    = 6;
    localparam int IMG_H    = 4;
    localparam int RD_LAT   = 2;
    localparam int ADDR_W   = $clog2(IMG_W * IMG_H);
    localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int FRAME    = H_TOTAL * V_TOTAL;
    localparam int LAT      = RD_LAT + 1;

    logic              clk;
    logic              rst;
    logic              pix_ce;
    logic              mem_en;
    logic [ADDR_W-1:0] mem_addr;
    logic [23:0]       mem_rdata;
    logic [7:0]        red;
    logic [7:0]        green;
    logic [7:0]        blue;
    logic              de;
    logic              hsync_n;
    logic              vsync_n;
    logic              frame_start;

    vga_pixel_source #(
        .H_ACTIVE (H_ACTIVE),
        .H_FP     (H_FP),
        .H_SYNC   (H_SYNC),
        .H_BP     (H_BP),
        .V_ACTIVE (V_ACTIVE),
        .V_FP     (V_FP),
        .V_SYNC   (V_SYNC),
        .V_BP     (V_BP),
        .IMG_W    (IMG_W),
        .IMG_H    (IMG_H),
        .RD_LAT   (RD_LAT),
        .ADDR_W   (ADDR_W)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .pix_ce      (pix_ce),
        .mem_en      (mem_en),
        .mem_addr    (mem_addr),
        .mem_rdata   (mem_rdata),
        .red         (red),
        .green       (green),
        .blue        (blue),
        .de          (de),
        .hsync_n     (hsync_n),
        .vsync_n     (vsync_n),
        .frame_start (frame_start)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Frame-buffer contents (random) and a BRAM with RD_LAT enabled-cycle latency.
    logic [23:0]       mem_data [1 << ADDR_W];
    logic [ADDR_W-1:0] bram_q   [RD_LAT];

    always @(posedge clk) begin
        if (mem_en) begin
            bram_q[0] <= mem_addr;
            for (int i = 1; i < RD_LAT; i++) begin
                bram_q[i] <= bram_q[i-1];
            end
        end
    end
    assign mem_rdata = mem_data[bram_q[RD_LAT-1]];

    int n_checks = 0;
    int n_errors = 0;
    int m        = 0;   // pixel ticks since reset release = index of current counter state
    int last_fs  = -1;  // tick count at the previous observed frame_start
    int max_seen = 0;   // highest mem_addr presented while mem_en

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t, tick=%0d)", tag, got, exp, $time, m);
        end
    endtask

    // Compare every output against the raster position LAT ticks in the past.
    task automatic verify(input logic ce, input logic r);
        int          idx;
        int          h;
        int          v;
        int          sh;
        int          sv;
        logic        e_de;
        logic        e_hsn;
        logic        e_vsn;
        logic        e_fs;
        logic [23:0] e_rgb;

        e_de  = 1'b0;
        e_hsn = 1'b1;
        e_vsn = 1'b1;
        e_fs  = 1'b0;
        e_rgb = 24'h0;
        idx   = m - LAT;
        if (!r && idx >= 0) begin
            h     = idx % H_TOTAL;
            v     = (idx / H_TOTAL) % V_TOTAL;
            e_de  = (h < H_ACTIVE) && (v < V_ACTIVE);
            e_hsn = !((h >= H_ACTIVE + H_FP) && (h < H_ACTIVE + H_FP + H_SYNC));
            e_vsn = !((v >= V_ACTIVE + V_FP) && (v < V_ACTIVE + V_FP + V_SYNC));
            if (h < IMG_W && v < IMG_H) e_rgb = mem_data[v * IMG_W + h];
            e_fs  = ce && (idx % FRAME == 0);
        end

        check("de",          32'(de),                 32'(e_de));
        check("hsync_n",     32'(hsync_n),            32'(e_hsn));
        check("vsync_n",     32'(vsync_n),            32'(e_vsn));
        check("rgb",         32'({red, green, blue}), 32'(e_rgb));
        check("frame_start", 32'(frame_start),        32'(e_fs));
        check("mem_en",      32'(mem_en),             32'(ce && !r));

        // Address of the current raster position, when it lies in the image.
        sh = m % H_TOTAL;
        sv = (m / H_TOTAL) % V_TOTAL;
        if (sh < IMG_W && sv < IMG_H) begin
            check("mem_addr", 32'(mem_addr), 32'(sv * IMG_W + sh));
        end
        if (mem_en && int'(mem_addr) > max_seen) max_seen = int'(mem_addr);

        if (frame_start) begin
            if (last_fs < 0) check("fs_first_tick", 32'(m), 32'(LAT));
            else             check("fs_spacing",    32'(m - last_fs), 32'(FRAME));
            last_fs = m;
        end
    endtask

    // Drive one clk, update the tick model at the edge, check at the falling edge.
    task automatic step(input logic ce, input logic r);
        pix_ce = ce;
        rst    = r;
        @(posedge clk);
        if (r) begin
            m       = 0;
            last_fs = -1;
        end else if (ce) begin
            m++;
        end
        @(negedge clk);
        verify(ce, r);
    endtask

    initial begin
        for (int i = 0; i < (1 << ADDR_W); i++) mem_data[i] = 24'($urandom);
        for (int i = 0; i < RD_LAT; i++) bram_q[i] = '0;
        pix_ce = 1'b0;
        rst    = 1'b1;

        // Reset, with pix_ce toggling to show reset priority.
        for (int i = 0; i < 3; i++) step(1'($urandom_range(0, 1)), 1'b1);

        // Full rate, two frames plus the start of a third.
        max_seen = 0;
        for (int i = 0; i < 2 * FRAME + 5; i++) step(1'b1, 1'b0);
        check("max_addr_full", 32'(max_seen), 32'(IMG_W * IMG_H - 1));

        // Sparse pix_ce, every 4th clk.
        step(1'b1, 1'b1);
        max_seen = 0;
        for (int i = 0; i < FRAME + 5; i++) begin
            step(1'b0, 1'b0);
            step(1'b0, 1'b0);
            step(1'b0, 1'b0);
            step(1'b1, 1'b0);
        end
        check("max_addr_sparse", 32'(max_seen), 32'(IMG_W * IMG_H - 1));

        // Mid-frame reset inside the active region but outside the image.
        step(1'b1, 1'b1);
        for (int i = 0; i < 6 * H_TOTAL + 12; i++) step(1'b1, 1'b0);
        step(1'b1, 1'b1);
        step(1'b1, 1'b1);

        // Random pix_ce density after the mid-frame reset.
        max_seen = 0;
        for (int i = 0; i < 3 * FRAME; i++) step(1'($urandom_range(0, 2) != 0), 1'b0);
        check("max_addr_random", 32'(max_seen), 32'(IMG_W * IMG_H - 1));

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, tick=%0d", m);
        $fatal(1, "time limit");
    end

endmodule
